// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler: drains NUM_Q look-ahead FIFOs onto one valid/ready stream,
// granting one queue at a time for bursts of up to BURST_LEN words.
//
// state | meaning
// IDLE  | no grant; searching for the next eligible queue after last_q
// GRANT | grant_id owns the output; words flow on each handshake
module fifo_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_Q      = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclr,
    input  logic [NUM_Q-1:0]              q_en,
    input  logic [NUM_Q-1:0]              q_empty,
    input  logic [NUM_Q*DATA_WIDTH-1:0]   q_data,
    output logic [NUM_Q-1:0]              q_rd_en,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_Q)-1:0]      grant_id,
    output logic                          busy,
    output logic                          burst_done
);
    localparam int QW = $clog2(NUM_Q);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [QW-1:0] LAST_Q_RST = QW'(NUM_Q - 1);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
    logic [QW-1:0]   last_q, last_q_nxt;
    logic [QW-1:0]   grant_nxt;
    logic            burst_done_nxt;
    logic [NUM_Q-1:0] eligible;
    logic            handshake;
    logic            found;
    logic [QW-1:0]   pick;
    int              idx;

    assign eligible = q_en & ~q_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_q     <= LAST_Q_RST;
            grant_id   <= '0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            last_q     <= last_q_nxt;
            grant_id   <= grant_nxt;
            burst_done <= burst_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        beat_cnt_nxt   = beat_cnt;
        last_q_nxt     = last_q;
        grant_nxt      = grant_id;
        burst_done_nxt = 1'b0;
        found          = 1'b0;
        pick           = '0;
        idx            = 0;
        handshake      = out_valid & out_ready;

        // first eligible queue strictly after last_q, wrapping
        for (int k = 1; k <= NUM_Q; k++) begin
            idx = (int'(last_q) + k) % NUM_Q;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx[QW-1:0];
            end
        end

        if (sclr) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
            last_q_nxt   = LAST_Q_RST;
            grant_nxt    = '0;
        end else if (state == IDLE) begin
            if (found) begin
                state_nxt    = GRANT;
                grant_nxt    = pick;
                beat_cnt_nxt = '0;
            end
        end else begin
            if (handshake) begin
                beat_cnt_nxt = beat_cnt + CW'(1);
            end
            if ((handshake && beat_cnt == LAST_BEAT) || !out_valid) begin
                state_nxt      = IDLE;
                last_q_nxt     = grant_id;
                burst_done_nxt = 1'b1;
            end
        end
    end

    // valid is masked by sclr so a consumer never takes a word whose read is suppressed
    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        q_rd_en   = '0;
        if (state == GRANT) begin
            busy               = 1'b1;
            out_data           = q_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            out_valid          = eligible[grant_id] & ~sclr;
            q_rd_en[grant_id]  = out_valid & out_ready;
        end
    end
endmodule
